// File: rtl/piso_sched_if.sv
// Requester handshake and PISO control bundle for piso_sched.
// master = requester/PISO side, slave = scheduler.
interface piso_sched_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic                    hold;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*WIDTH-1:0]   req_data;
    logic [NREQ-1:0]         req_ready;
    logic                    piso_load;
    logic [WIDTH-1:0]        piso_data;
    logic                    busy;
    logic [IDW-1:0]          grant_id;
    logic                    frame_done;

    modport master (
        output hold, req_valid, req_data,
        input  req_ready, piso_load, piso_data, busy, grant_id, frame_done
    );

    modport slave (
        input  hold, req_valid, req_data,
        output req_ready, piso_load, piso_data, busy, grant_id, frame_done
    );
endinterface

// File: rtl/piso_sched.sv
// Round-robin scheduler sharing one PISO serializer between NREQ requesters.
//   state | meaning
//   IDLE  | arbitrate; req_ready to the winner unless hold
//   LOAD  | one-cycle load strobe to the PISO, counter preset
//   SHIFT | WIDTH cycles while the PISO shifts; frame_done on the last
module piso_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input logic          clk,
    input logic          rst,
    piso_sched_if.slave  bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;

    logic [1:0]     state;
    logic [CW-1:0]  cnt;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] winner;
    logic           found;
    logic           accept;

    // Search upward from the slot after the last grant, wrapping modulo NREQ.
    always_comb begin
        found  = 1'b0;
        winner = last_grant;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && bus.req_valid[(int'(last_grant) + k) % NREQ]) begin
                found  = 1'b1;
                winner = IDW'((int'(last_grant) + k) % NREQ);
            end
        end
    end

    assign accept         = (state == S_IDLE) && !bus.hold && found;
    assign bus.req_ready  = accept ? ({{(NREQ-1){1'b0}}, 1'b1} << winner) : '0;
    assign bus.busy       = (state != S_IDLE);
    assign bus.frame_done = (state == S_SHIFT) && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            bus.piso_load <= 1'b0;
            bus.piso_data <= '0;
            bus.grant_id  <= '0;
            last_grant    <= IDW'(NREQ - 1);
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        bus.piso_data <= bus.req_data[winner*WIDTH +: WIDTH];
                        bus.grant_id  <= winner;
                        last_grant    <= winner;
                        bus.piso_load <= 1'b1;
                        state         <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    bus.piso_load <= 1'b0;
                    cnt           <= CW'(WIDTH - 1);
                    state         <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    bus.piso_load <= 1'b0;
                    state         <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_piso_sched.sv
// Scoreboard bench for piso_sched: expected {grant_id, piso_data} queued at
// stimulus time, popped on each piso_load; a per-cycle monitor checks framing.
module tb_piso_sched;
    localparam int NREQ  = 4;
    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    piso_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    piso_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] sb[$];
    logic       mon_en    = 1'b0;
    logic       prev_busy = 1'b0;
    logic       chk_gap   = 1'b0;
    logic       have_prev = 1'b0;
    int         last_load = 0;
    int         cd = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Per-cycle monitor: scoreboard pop on load, framing model, protocol rules.
    always @(negedge clk) begin
        logic [7:0] e;
        if (mon_en) begin
            check_val("ready_onehot", 32'($countones(bus.req_ready) > 1), 0);
            check_val("load_in_rst", 32'(rst & bus.piso_load), 0);
            check_val("load_after_busy", 32'(bus.piso_load & prev_busy), 0);
            if (bus.piso_load) begin
                check_val("load_expected", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_val("grant_id", 32'(bus.grant_id), 32'(e[7:4]));
                    check_val("piso_data", 32'(bus.piso_data), 32'(e[3:0]));
                end
                if (chk_gap && have_prev) check_val("load_gap", cyc - last_load, WIDTH + 2);
                last_load = cyc;
                have_prev = 1'b1;
                check_val("busy_load", 32'(bus.busy), 1);
                check_val("frame_done_load", 32'(bus.frame_done), 0);
                cd = WIDTH;
            end else begin
                check_val("busy", 32'(bus.busy), 32'(cd > 0));
                if (cd > 0) begin
                    cd--;
                    check_val("frame_done", 32'(bus.frame_done), 32'(cd == 0));
                end else begin
                    check_val("frame_done_idle", 32'(bus.frame_done), 0);
                end
            end
            if (rst) cd = 0;
            prev_busy = bus.busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_load(input int maxc);
        int n = 0;
        while (!bus.piso_load && n < maxc) begin
            tick();
            n++;
        end
        check_val("wait_load", 32'(bus.piso_load), 1);
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while (bus.busy && n < maxc) begin
            tick();
            n++;
        end
        check_val("wait_idle", 32'(bus.busy), 0);
    endtask

    task automatic wait_sb(input int maxc);
        int n = 0;
        while (sb.size() != 0 && n < maxc) begin
            tick();
            n++;
        end
        check_val("wait_sb", sb.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_ready"}, 32'(bus.req_ready), 0);
        check_val({tag, "_load"}, 32'(bus.piso_load), 0);
        check_val({tag, "_data"}, 32'(bus.piso_data), 0);
        check_val({tag, "_busy"}, 32'(bus.busy), 0);
        check_val({tag, "_grant"}, 32'(bus.grant_id), 0);
        check_val({tag, "_fdone"}, 32'(bus.frame_done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.hold      = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        do_reset();
        check_zero_outputs("reset");
        mon_en = 1'b1;

        // Single request from requester 0.
        bus.req_valid = 4'b0001;
        bus.req_data  = 16'h000A;
        #1;
        check_val("single_ready", 32'(bus.req_ready), 32'h1);
        sb.push_back({4'd0, 4'hA});
        wait_load(4);
        bus.req_valid = '0;
        wait_idle(20);
        check_val("single_grant_hold", 32'(bus.grant_id), 0);

        // One requester held valid: granted every WIDTH+2 cycles.
        have_prev = 1'b0;
        chk_gap   = 1'b1;
        bus.req_valid = 4'b0001;
        bus.req_data  = 16'h0006;
        repeat (3) sb.push_back({4'd0, 4'h6});
        wait_sb(40);
        bus.req_valid = '0;
        chk_gap = 1'b0;
        wait_idle(20);

        // All requesters valid after reset: rotate 0,1,2,3,0.
        do_reset();
        have_prev = 1'b0;
        chk_gap   = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_data  = 16'h4321;
        sb.push_back({4'd0, 4'h1});
        sb.push_back({4'd1, 4'h2});
        sb.push_back({4'd2, 4'h3});
        sb.push_back({4'd3, 4'h4});
        sb.push_back({4'd0, 4'h1});
        wait_sb(60);
        bus.req_valid = '0;
        chk_gap = 1'b0;
        wait_idle(20);

        // Move last_grant to 1, then 1010 must alternate 3,1,3,1.
        bus.req_valid = 4'b0010;
        bus.req_data  = 16'h00B0;
        sb.push_back({4'd1, 4'hB});
        wait_load(4);
        bus.req_valid = '0;
        wait_idle(20);
        have_prev = 1'b0;
        chk_gap   = 1'b1;
        bus.req_valid = 4'b1010;
        bus.req_data  = 16'hC050;
        sb.push_back({4'd3, 4'hC});
        sb.push_back({4'd1, 4'h5});
        sb.push_back({4'd3, 4'hC});
        sb.push_back({4'd1, 4'h5});
        wait_sb(50);
        bus.req_valid = '0;
        chk_gap = 1'b0;
        wait_idle(20);

        // Hold blocks grants; release grants same cycle; hold mid-frame is ignored.
        bus.hold      = 1'b1;
        bus.req_valid = 4'b0100;
        bus.req_data  = 16'h0700;
        repeat (10) begin
            tick();
            check_val("hold_ready", 32'(bus.req_ready), 0);
            check_val("hold_load", 32'(bus.piso_load), 0);
        end
        bus.hold = 1'b0;
        #1;
        check_val("release_ready", 32'(bus.req_ready), 32'h4);
        sb.push_back({4'd2, 4'h7});
        wait_load(2);
        tick();
        bus.hold = 1'b1;
        wait_idle(20);
        repeat (3) begin
            tick();
            check_val("hold_after_ready", 32'(bus.req_ready), 0);
        end
        bus.hold      = 1'b0;
        bus.req_valid = '0;

        // Reset during the second SHIFT cycle abandons the frame.
        bus.req_valid = 4'b0001;
        bus.req_data  = 16'h0009;
        sb.push_back({4'd0, 4'h9});
        wait_load(4);
        bus.req_valid = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_zero_outputs("midrst");
        rst = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_data  = 16'h4321;
        #1;
        check_val("post_rst_ready", 32'(bus.req_ready), 32'h1);
        sb.push_back({4'd0, 4'h1});
        wait_load(4);
        bus.req_valid = '0;
        wait_idle(20);
        wait_sb(5);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
